// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select encodings, controller states and register-specifier width.
package hazard_pkg;

    localparam int REG_AW_DEFAULT = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hazState_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage forwarding select for one ALU operand.
// The M-stage result takes priority over the W-stage result.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = REG_AW_DEFAULT
) (
    input  logic [AW-1:0] srcReg,
    input  logic [AW-1:0] writeRegM,
    input  logic [AW-1:0] writeRegW,
    input  logic          regWriteM,
    input  logic          regWriteW,
    output logic [1:0]    fwdSel
);

    logic hitM;
    logic hitW;

    assign hitM = regWriteM && (writeRegM != '0) && (writeRegM == srcReg);
    assign hitW = regWriteW && (writeRegW != '0) && (writeRegW == srcReg);

    always_comb begin
        fwdSel = FWD_RF;
        if (hitM) begin
            fwdSel = FWD_MEM;
        end else if (hitW) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for the 5-stage pipeline.
// Define HAZ_PERF_EN to build the saturating stall performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEFAULT,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              BranchD,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr,
    output logic [CNT_W-1:0]  LoadStallCnt,
    output logic [CNT_W-1:0]  BranchStallCnt,
    output logic [CNT_W-1:0]  MemStallCnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hazState_t  state;
    logic [7:0] waitCnt;
    logic       memErrQ;

    logic [1:0] fwdAE;
    logic [1:0] fwdBE;
    logic       fwdAD;
    logic       fwdBD;
    logic       lwStall;
    logic       brStall;
    logic       memStall;
    logic       hazStall;
    logic       freeze;
    logic       srcHitE;
    logic       srcHitM;

    fwd_sel #(.AW(REG_AW)) uFwdA (
        .srcReg    (RsE),
        .writeRegM (WriteRegM),
        .writeRegW (WriteRegW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdAE)
    );

    fwd_sel #(.AW(REG_AW)) uFwdB (
        .srcReg    (RtE),
        .writeRegM (WriteRegM),
        .writeRegW (WriteRegW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdBE)
    );

    assign fwdAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
    assign fwdBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);

    assign lwStall = MemtoRegE && (RtE != '0)
                  && ((RtE == RsD) || (RtE == RtD));

    assign srcHitE = RegWriteE && (WriteRegE != '0)
                  && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign srcHitM = MemtoRegM && (WriteRegM != '0)
                  && ((WriteRegM == RsD) || (WriteRegM == RtD));
    assign brStall = BranchD && (srcHitE || srcHitM);

    assign memStall = MemReqM && !MemReadyM;
    assign hazStall = lwStall || brStall;

    // A frozen pipeline must not also inject a bubble into E.
    assign freeze = (state == ERR) || memStall;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (rst_n) begin
            ForwardAE = fwdAE;
            ForwardBE = fwdBE;
            ForwardAD = fwdAD;
            ForwardBD = fwdBD;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = hazStall;
                StallD = hazStall;
                FlushE = hazStall;
                FlushW = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            waitCnt <= '0;
            memErrQ <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (memStall) begin
                        state   <= WAIT;
                        waitCnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (!memStall) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_LAST) begin
                        state   <= ERR;
                        memErrQ <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                ERR: begin
                    memErrQ <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    assign MemErr = memErrQ;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] ldCnt;
    logic [CNT_W-1:0] brCnt;
    logic [CNT_W-1:0] memCnt;
    logic             runEq;
    logic             memFrz;

    assign runEq  = (state != ERR) && !memStall;
    assign memFrz = (state != ERR) && memStall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldCnt  <= '0;
            brCnt  <= '0;
            memCnt <= '0;
        end else begin
            if (runEq && lwStall && (ldCnt != '1)) begin
                ldCnt <= ldCnt + CNT_W'(1);
            end
            if (runEq && brStall && !lwStall && (brCnt != '1)) begin
                brCnt <= brCnt + CNT_W'(1);
            end
            if (memFrz && (memCnt != '1)) begin
                memCnt <= memCnt + CNT_W'(1);
            end
        end
    end

    assign LoadStallCnt   = ldCnt;
    assign BranchStallCnt = brCnt;
    assign MemStallCnt    = memCnt;
`else
    assign LoadStallCnt   = '0;
    assign BranchStallCnt = '0;
    assign MemStallCnt    = '0;
`endif

endmodule
